// File: rtl/oq_sched_pkg.sv
// Shared definitions for the output-queue scheduler: FSM state encoding and
// default queue geometry used by the SRAM output-queue blocks.
package oq_sched_pkg;

  localparam int unsigned OQ_NUM_QUEUES     = 5;
  localparam int unsigned OQ_QUEUE_ID_WIDTH = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2
  } oq_state_t;

endpackage

// File: rtl/oq_rr_scheduler_rr_pick.sv
// Combinational round-robin search: first set bit of eligible at or after
// rr_ptr, wrapping at NUM_QUEUES-1 back to 0.
module rr_pick
  import oq_sched_pkg::*;
#(
  parameter int unsigned NUM_QUEUES     = OQ_NUM_QUEUES,
  parameter int unsigned QUEUE_ID_WIDTH = OQ_QUEUE_ID_WIDTH
) (
  input  logic [NUM_QUEUES-1:0]     eligible,
  input  logic [QUEUE_ID_WIDTH-1:0] rr_ptr,
  output logic                      found,
  output logic [QUEUE_ID_WIDTH-1:0] idx
);

  int unsigned cand;

  // rr_ptr is always < NUM_QUEUES, so one conditional subtract wraps the offset.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = 0;
    for (int unsigned i = 0; i < NUM_QUEUES; i++) begin
      cand = 32'(rr_ptr) + i;
      if (cand >= NUM_QUEUES) cand = cand - NUM_QUEUES;
      if (!found && eligible[cand[QUEUE_ID_WIDTH-1:0]]) begin
        found = 1'b1;
        idx   = cand[QUEUE_ID_WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/oq_rr_scheduler.sv
// Round-robin scheduler issuing one packet read at a time to the SRAM reader.
// Optional watchdog on the XFER phase enabled by defining OQ_SCHED_WATCHDOG_EN.
module oq_rr_scheduler
  import oq_sched_pkg::*;
#(
  parameter int unsigned NUM_QUEUES     = OQ_NUM_QUEUES,
  parameter int unsigned QUEUE_ID_WIDTH = OQ_QUEUE_ID_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_QUEUES-1:0]     q_nonempty,
  input  logic [NUM_QUEUES-1:0]     q_dst_ready,
  output logic                      rd_req,
  output logic [QUEUE_ID_WIDTH-1:0] rd_qid,
  input  logic                      rd_ack,
  input  logic                      pkt_done,
  output logic [NUM_QUEUES-1:0]     grant,
  output logic                      busy,
  output logic                      err_timeout
);

  if ((1 << QUEUE_ID_WIDTH) < NUM_QUEUES) begin : g_bad_qid_width
    $error("QUEUE_ID_WIDTH too small for NUM_QUEUES");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  oq_state_t                 state, state_nxt;
  logic [QUEUE_ID_WIDTH-1:0] rr_ptr;
  logic [QUEUE_ID_WIDTH-1:0] qid;
  logic [QUEUE_ID_WIDTH-1:0] qid_inc;
  logic [QUEUE_ID_WIDTH-1:0] pick_idx;
  logic                      pick_found;
  logic                      wd_expire;
  logic                      pkt_end;

  rr_pick #(
    .NUM_QUEUES     (NUM_QUEUES),
    .QUEUE_ID_WIDTH (QUEUE_ID_WIDTH)
  ) u_rr_pick (
    .eligible (q_nonempty & q_dst_ready),
    .rr_ptr   (rr_ptr),
    .found    (pick_found),
    .idx      (pick_idx)
  );

  assign qid_inc = (qid == QUEUE_ID_WIDTH'(NUM_QUEUES - 1)) ? '0 : qid + 1'b1;

  // A packet ends on single-word ack+done in REQ, on done in XFER, or on timeout.
  assign pkt_end = ((state == REQ) && rd_ack && pkt_done) ||
                   ((state == XFER) && (pkt_done || wd_expire));

`ifdef OQ_SCHED_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES);

  logic [WD_W-1:0] wd_cnt;

  assign wd_expire = (state == XFER) && !pkt_done &&
                     (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt      <= '0;
      err_timeout <= 1'b0;
    end else begin
      err_timeout <= wd_expire;
      if ((state == REQ) && rd_ack) wd_cnt <= '0;
      else if (state == XFER)       wd_cnt <= wd_cnt + 1'b1;
    end
  end
`else
  assign wd_expire   = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      rr_ptr <= '0;
      qid    <= '0;
    end else begin
      state <= state_nxt;
      if ((state == IDLE) && pick_found) qid <= pick_idx;
      if (pkt_end) rr_ptr <= qid_inc;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_found) state_nxt = REQ;
      REQ:     if (rd_ack) state_nxt = pkt_done ? IDLE : XFER;
      XFER:    if (pkt_done || wd_expire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state == REQ) || (state == XFER);
    rd_req = (state == REQ);
    rd_qid = busy ? qid : '0;
    grant  = '0;
    for (int unsigned i = 0; i < NUM_QUEUES; i++) begin
      grant[i] = busy && (qid == QUEUE_ID_WIDTH'(i));
    end
  end

endmodule

// File: tb/tb_oq_rr_scheduler.sv
// Directed bench for oq_rr_scheduler; watchdog checks follow OQ_SCHED_WATCHDOG_EN.
module tb_oq_rr_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] q_nonempty;
  logic [4:0] q_dst_ready;
  logic       rd_req;
  logic [2:0] rd_qid;
  logic       rd_ack;
  logic       pkt_done;
  logic [4:0] grant;
  logic       busy;
  logic       err_timeout;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  oq_rr_scheduler #(
    .NUM_QUEUES     (5),
    .QUEUE_ID_WIDTH (3),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .q_nonempty  (q_nonempty),
    .q_dst_ready (q_dst_ready),
    .rd_req      (rd_req),
    .rd_qid      (rd_qid),
    .rd_ack      (rd_ack),
    .pkt_done    (pkt_done),
    .grant       (grant),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    check({tag, ".rd_req"}, 32'(rd_req), 32'd0);
    check({tag, ".rd_qid"}, 32'(rd_qid), 32'd0);
    check({tag, ".grant"},  32'(grant),  32'd0);
    check({tag, ".busy"},   32'(busy),   32'd0);
    check({tag, ".err"},    32'(err_timeout), 32'd0);
  endtask

  task automatic chk_req(input string tag, input int q);
    logic [4:0] oh;
    oh = 5'd1 << q;
    check({tag, ".rd_req"}, 32'(rd_req), 32'd1);
    check({tag, ".rd_qid"}, 32'(rd_qid), 32'(q));
    check({tag, ".grant"},  32'(grant),  32'(oh));
    check({tag, ".busy"},   32'(busy),   32'd1);
  endtask

  // From IDLE with eligibility already driven: request, ack, optional XFER, done.
  task automatic serve(input string tag, input int q, input bit single);
    logic [4:0] oh;
    oh = 5'd1 << q;
    tick();
    chk_req(tag, q);
    rd_ack   = 1'b1;
    pkt_done = single;
    tick();
    rd_ack   = 1'b0;
    pkt_done = 1'b0;
    if (!single) begin
      check({tag, ".xfer_rd_req"}, 32'(rd_req), 32'd0);
      check({tag, ".xfer_grant"},  32'(grant),  32'(oh));
      check({tag, ".xfer_busy"},   32'(busy),   32'd1);
      pkt_done = 1'b1;
      tick();
      pkt_done = 1'b0;
    end
    chk_idle({tag, ".done"});
  endtask

  initial begin
    reset       = 1'b1;
    q_nonempty  = '0;
    q_dst_ready = '0;
    rd_ack      = 1'b0;
    pkt_done    = 1'b0;
    tick();
    tick();
    chk_idle("reset");
    reset = 1'b0;

    // Single queue 2: request at cycle 1, ack at 3, done at 10, IDLE at 11.
    q_nonempty  = 5'b00100;
    q_dst_ready = 5'b11111;
    tick();
    chk_req("single.c1", 2);
    q_nonempty = 5'b00000;
    tick();
    chk_req("single.hold_c2", 2);
    tick();
    chk_req("single.hold_c3", 2);
    rd_ack = 1'b1;
    tick();
    check("single.xfer_rd_req", 32'(rd_req), 32'd0);
    check("single.xfer_grant",  32'(grant),  32'h04);
    check("single.xfer_busy",   32'(busy),   32'd1);
    tick();
    rd_ack = 1'b0;
    check("single.ack_in_xfer", 32'(rd_req), 32'd0);
    repeat (5) tick();
    check("single.c10_busy", 32'(busy), 32'd1);
    pkt_done = 1'b1;
    tick();
    pkt_done = 1'b0;
    chk_idle("single.c11");

    // rr_ptr now 3: all eligible picks 3; single-word leaves rr_ptr=4.
    q_nonempty = 5'b11111;
    serve("ptr3", 3, 1'b1);

    // Wrap from rr_ptr=4 with only 0 and 1 eligible.
    q_nonempty = 5'b00011;
    serve("wrap", 0, 1'b1);
    serve("same_cycle_q1", 1, 1'b1);
    q_nonempty = 5'b11111;
    serve("after_q1", 2, 1'b0);

    // Queue 4 done must wrap rr_ptr to 0, not 5.
    q_nonempty = 5'b10000;
    serve("q4", 4, 1'b1);
    q_nonempty = 5'b00000;
    rd_ack     = 1'b1;
    pkt_done   = 1'b1;
    tick();
    chk_idle("idle_ignore1");
    tick();
    chk_idle("idle_ignore2");
    rd_ack   = 1'b0;
    pkt_done = 1'b0;

    q_nonempty = 5'b11111;
    serve("fair0", 0, 1'b0);
    serve("fair1", 1, 1'b1);
    serve("fair2", 2, 1'b0);
    serve("fair3", 3, 1'b1);
    serve("fair4", 4, 1'b0);
    serve("fair0b", 0, 1'b1);

    // Set rr_ptr=4 then reset in the middle of a queue-4 XFER.
    q_nonempty = 5'b01000;
    serve("pre_rst", 3, 1'b1);
    q_nonempty = 5'b10000;
    tick();
    chk_req("rst.req", 4);
    rd_ack = 1'b1;
    tick();
    rd_ack = 1'b0;
    check("rst.in_xfer", 32'(busy), 32'd1);
    tick();
    reset = 1'b1;
    #1;
    chk_idle("rst.async");
    tick();
    chk_idle("rst.held");
    reset      = 1'b0;
    q_nonempty = 5'b11000;
    tick();
    chk_req("rst.after", 3);
    rd_ack   = 1'b1;
    pkt_done = 1'b1;
    tick();
    rd_ack   = 1'b0;
    pkt_done = 1'b0;
    chk_idle("rst.after_done");

    // Watchdog: queue 4 enters XFER and pkt_done never arrives.
    q_nonempty = 5'b10000;
    tick();
    chk_req("wd.req", 4);
    rd_ack = 1'b1;
    tick();
    rd_ack = 1'b0;
    check("wd.entry_busy", 32'(busy), 32'd1);
`ifdef OQ_SCHED_WATCHDOG_EN
    repeat (15) tick();
    check("wd.e15_err",  32'(err_timeout), 32'd0);
    check("wd.e15_busy", 32'(busy),        32'd1);
    q_nonempty = 5'b00000;
    tick();
    check("wd.e16_err",  32'(err_timeout), 32'd1);
    check("wd.e16_busy", 32'(busy),        32'd0);
    tick();
    chk_idle("wd.e17");
    q_nonempty = 5'b11111;
    serve("wd.ptr_adv", 0, 1'b1);
`else
    for (int i = 0; i < 20; i++) begin
      tick();
      check("wd.off_err", 32'(err_timeout), 32'd0);
    end
    check("wd.off_busy", 32'(busy), 32'd1);
    pkt_done = 1'b1;
    tick();
    pkt_done = 1'b0;
    chk_idle("wd.off_done");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/oq_rr_scheduler.md
OQ_RR_SCHEDULER -- requirements
Module: oq_rr_scheduler

Interface
REQ-001 SHALL have parameter NUM_QUEUES, default 5: number of output queues arbitrated.
REQ-002 SHALL have parameter QUEUE_ID_WIDTH, default 3: width of queue index; 2^QUEUE_ID_WIDTH >= NUM_QUEUES.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 4096: watchdog limit for one packet read.
REQ-004 SHALL have ports:
- clk  input  1  sole clock.
- reset  input  1  asynchronous, active-high.
- q_nonempty  input  NUM_QUEUES  bit i set: queue i holds at least one complete packet.
- q_dst_ready  input  NUM_QUEUES  bit i set: egress port i can accept a packet.
- rd_req  output  1  read request to the SRAM reader.
- rd_qid  output  QUEUE_ID_WIDTH  queue to read; valid while rd_req is high.
- rd_ack  input  1  reader accepted the request.
- pkt_done  input  1  reader issued the last word of the granted packet.
- grant  output  NUM_QUEUES  one-hot of the queue currently being served.
- busy  output  1  high in REQ or XFER.
- err_timeout  output  1  one-cycle pulse on watchdog expiry.

Function
REQ-005 SHALL use the FSM states IDLE, REQ and XFER.
REQ-006 In IDLE, eligible = q_nonempty & q_dst_ready; the winner SHALL be the first eligible index at or after rr_ptr, searching upward and wrapping from NUM_QUEUES-1 to 0.
REQ-007 If an eligible queue is seen in IDLE at cycle N, the FSM SHALL be in REQ at N+1 with rd_req=1, rd_qid=winner and grant=onehot(winner).
REQ-008 In REQ, rd_req, rd_qid and grant SHALL stay stable until rd_ack; a change in eligibility SHALL NOT withdraw the request.
REQ-009 rd_ack in REQ SHALL move the FSM to XFER and deassert rd_req on the next cycle; grant SHALL stay held.
REQ-010 If rd_ack and pkt_done are both high in REQ, the packet SHALL be treated as single-word and the FSM SHALL go directly to IDLE.
REQ-011 pkt_done in XFER SHALL return the FSM to IDLE and set rr_ptr to (qid+1) mod NUM_QUEUES, wrapping at NUM_QUEUES-1 and not at 2^QUEUE_ID_WIDTH.
REQ-012 pkt_done outside REQ/XFER and rd_ack outside REQ SHALL be ignored.
REQ-013 There SHALL be at most one packet outstanding; there SHALL be no back-to-back grant, because every packet passes through IDLE for at least one cycle.
REQ-014 No eligible queue in IDLE SHALL leave all outputs at their reset values.
REQ-015 Indices >= NUM_QUEUES SHALL never be issued.

Reset
REQ-016 While reset is high, outputs SHALL be rd_req=0, rd_qid=0, grant=0, busy=0 and err_timeout=0, with state=IDLE, rr_ptr=0 and watchdog=0.
REQ-017 Reset asserted in REQ or XFER SHALL abandon the packet immediately with no completion pulse.
REQ-018 The first active clock edge after reset release SHALL be treated as IDLE.

Configuration
REQ-019 With OQ_SCHED_WATCHDOG_EN defined, a counter SHALL clear on entry to XFER and increment each XFER cycle. On reaching TIMEOUT_CYCLES-1 without pkt_done, the block SHALL pulse err_timeout for one cycle, advance rr_ptr as in REQ-011, and return to IDLE.
REQ-020 Without OQ_SCHED_WATCHDOG_EN, no counter SHALL be built, err_timeout SHALL be tied to 0, and XFER SHALL wait indefinitely.

Structure
REQ-021 Package oq_sched_pkg SHALL hold the state enum (IDLE/REQ/XFER) and the NUM_QUEUES and QUEUE_ID_WIDTH defaults shared with the SRAM output-queue blocks.
REQ-022 The combinational round-robin search SHALL be a sub-module rr_pick: inputs eligible and rr_ptr, outputs found and idx.

Verification
REQ-023 Single queue: q_nonempty=5'b00100 and q_dst_ready=all-ones at cycle 0 -> rd_req=1, rd_qid=2 at cycle 1; rd_ack at cycle 3 and pkt_done at cycle 10 -> IDLE at cycle 11 with rr_ptr=3.
REQ-024 Fairness: all queues eligible, five packets -> grant order 0,1,2,3,4 and then 0 again.
REQ-025 Wrap: rr_ptr=4, eligible=5'b00011 -> rd_qid=0.
REQ-026 Same-cycle rd_ack+pkt_done in REQ for qid 1 -> IDLE next cycle, rr_ptr=2, busy=0.
REQ-027 Reset pulse mid-XFER -> all outputs 0 the same cycle; after release with queue 3 eligible, rd_qid=3 (search from rr_ptr=0).
REQ-028 With OQ_SCHED_WATCHDOG_EN and TIMEOUT_CYCLES=16, no pkt_done -> err_timeout pulses 16 cycles after XFER entry and the FSM returns to IDLE; without the macro, err_timeout stays 0.
